uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of the existing transmitter path. It synchronizes the raw `rx` pin, detects and validates start bits, and samples each bit at mid-bit from an internal clock-cycle counter. It checks optional parity and the stop bit(s), then presents the byte in a single holding register with a valid/read handshake and error flags. It sits between the board RX pin and the user logic that consumes received bytes; its framing parameters and runtime parity controls match the transmitter.

## Interface
- `CLOCK_FREQ`, 50000000: system clock frequency, Hz.
- `BAUD_RATE`, 9600: line rate, bit/s. `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE` (integer division, must be ≥ 4). `HALF = CLKS_PER_BIT / 2`.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: raw serial line; idles high; asynchronous to `clk`.
- `enable_parity` in 1: 1 means one parity bit follows the data.
- `parity_type` in 1: 0 = even, 1 = odd.
- `read` in 1: single-cycle pulse; consumes the held byte.
- `rx_data` out DATA_BITS: last accepted byte, LSB is the first bit received.
- `data_valid` out 1: the holding register contains unread data.
- `done` out 1: one-cycle pulse at frame commit.
- `busy` out 1: the FSM is not in IDLE.
- `parity_error` out 1: parity mismatch on the last committed frame.
- `frame_error` out 1: a stop bit sampled 0 on the last committed frame.
- `overrun` out 1: sticky; a frame completed while `data_valid` was 1.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- **Counter.** `cnt` is wide enough to hold `CLKS_PER_BIT-1`. `bit_idx` counts data bits and stop bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - On `rx_s==0`, go to START and clear `cnt`.
  - Latch `enable_parity` and `parity_type` for this frame. Changes to these inputs mid-frame are ignored.
- **START**
  - At `cnt==HALF-1`, sample `rx_s`.
  - If 0, go to DATA with `cnt=0` and `bit_idx=0`.
  - If 1, treat it as a glitch: return to IDLE, with no flags and no `done`.
- **DATA**
  - At `cnt==CLKS_PER_BIT-1`, shift `rx_s` into the MSB of the shift register (the LSB-first line order therefore lands correctly), clear `cnt`, and increment `bit_idx`.
  - After `DATA_BITS` samples, go to PARITY if parity is latched on, otherwise go to STOP.
- **PARITY**
  - Sample at full bit period.
  - `perr = rx_s ^ (^shift) ^ parity_type_latched`.
- **STOP**
  - Sample `STOP_BITS` times at full bit periods. Any 0 sets `ferr`.
  - After the last stop sample, commit and go to IDLE in the same cycle. No wait for the end of the stop bit, which allows back-to-back frames.
- **Commit, `data_valid==0` or `read==1` in this cycle**
  - `rx_data<=shift`, `data_valid<=1`.
  - `parity_error<=perr`, `frame_error<=ferr`.
  - `done<=1` for one cycle.
- **Commit, `data_valid==1` and no `read`**
  - The new frame is discarded; `rx_data` and the error flags keep the old frame's values.
  - `overrun<=1`, and `done` still pulses.
- **Read**
  - `read` while `data_valid==1` clears `data_valid` and `overrun`.
  - `read` while `data_valid==0` has no effect.
- **Error frames.** Frames with parity or framing errors are still committed, with their flags set.

## Timing
- **Reset values:** all outputs 0, state IDLE, `cnt=0`, synchronizer flops 1.
- **Reset mid-frame:** the frame is aborted immediately and nothing is committed.
- **Synchronizer latency:** `rx_s` lags `rx` by 2 cycles.
- **Sample points.** Let t0 be the first IDLE cycle with `rx_s==0`.
  - Start sample at t0+HALF.
  - Bit k (k = 1..N) sampled at t0+HALF+k·CLKS_PER_BIT, where N = DATA_BITS + parity + STOP_BITS.
- **Commit:** `done`, `data_valid`, `rx_data` and the flags update on the edge of the last stop sample, so they are visible the cycle after it.
- **`busy`:** high from t0+1 through the commit cycle.
- **Next frame:** IDLE accepts a new start edge one cycle after the commit.
- **Read path:** `read` clears `data_valid` on the following edge. There is no combinational path from `read` to any output.

## Test plan
Bench parameters: CLOCK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10 and HALF=5.

1. **Basic frame.** Send 0xA5 with no parity and a good stop bit. Expect: `rx_data`=0xA5, `data_valid`=1, one `done` pulse, `parity_error`=0, `frame_error`=0, `busy` low after the commit, commit at t0+95.
2. **Parity.** Send 0xA5 with the even parity bit=0, then again with `parity_type`=1 and parity bit=0. Expect: first frame `parity_error`=0; second frame `parity_error`=1 and data 0xA5.
3. **Glitch and framing.** Drive `rx` low for 3 cycles, then release. Expect: no `done`, `busy` returns to 0. Then send 0x3C with stop bit=0. Expect: `frame_error`=1, `rx_data`=0x3C.
4. **Overrun.** Send 0x11, then 0x22 without `read`. Expect: `rx_data`=0x11, `overrun`=1, two `done` pulses. Then pulse `read`. Expect: `data_valid`=0 and `overrun`=0.
5. **Read coincident with commit.** Pulse `read` in the same cycle as the commit of 0x22 while 0x11 is held. Expect: `rx_data`=0x22, `data_valid`=1, `overrun`=0.
6. **Reset and back-to-back.** Assert `rst_n` low mid-data. Expect: all outputs 0 and no commit. Then send 0x01 and 0xFE back-to-back with one stop bit. Expect: both bytes received in order.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling from a per-bit
// cycle counter, optional parity, 1-2 stop bits, single holding register with read handshake.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 enable_parity,
  input  logic                 parity_type,
  input  logic                 read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  output logic                 done,
  output logic                 busy,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int IW           = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic                 sync1, rx_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_en, par_en_n, par_odd, par_odd_n;
  logic                 perr, perr_n, ferr, ferr_n;
  logic                 commit;
  logic                 bit_end, half_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half_end = (cnt == CW'(HALF - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      par_en  <= par_en_n;
      par_odd <= par_odd_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    par_en_n  = par_en;
    par_odd_n = par_odd;
    perr_n    = perr;
    ferr_n    = ferr;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n   = START;
          par_en_n  = enable_parity;
          par_odd_n = parity_type;
          perr_n    = 1'b0;
          ferr_n    = 1'b0;
        end
      end
      START: begin
        if (half_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            bit_idx_n = '0;
            state_n   = par_en ? PARITY : STOP;
          end else begin
            bit_idx_n = bit_idx + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          perr_n  = rx_s ^ (^shift) ^ par_odd;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (!rx_s) ferr_n = 1'b1;
          // Commit on the last stop sample itself so a following start edge is not missed.
          if (bit_idx == IW'(STOP_BITS - 1)) begin
            commit    = 1'b1;
            bit_idx_n = '0;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + IW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      data_valid   <= 1'b0;
      done         <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done <= commit;
      if (commit && (!data_valid || read)) begin
        rx_data      <= shift;
        parity_error <= perr;
        frame_error  <= ferr_n;
        data_valid   <= 1'b1;
      end else if (read && data_valid) begin
        data_valid <= 1'b0;
      end
      // A read landing on the commit edge frees the register, so no overrun there.
      if (read && data_valid)
        overrun <= 1'b0;
      else if (commit && data_valid)
        overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_receiver;
  localparam int CLKS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       enable_parity = 1'b0;
  logic       parity_type = 1'b0;
  logic       read = 1'b0;
  logic [7:0] rx_data;
  logic       data_valid, done, busy, parity_error, frame_error, overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  logic [7:0] m_data = '0;
  bit m_valid = 0, m_perr = 0, m_ferr = 0, m_ovr = 0;
  int m_done = 0;

  uart_receiver #(
    .CLOCK_FREQ(1000000),
    .BAUD_RATE (100000),
    .DATA_BITS (8),
    .STOP_BITS (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .enable_parity(enable_parity),
    .parity_type  (parity_type),
    .read         (read),
    .rx_data      (rx_data),
    .data_valid   (data_valid),
    .done         (done),
    .busy         (busy),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Frame-level model: parity by popcount, holding register with overrun rule.
  task automatic model_commit(input logic [7:0] d, input bit pen, input bit ptype,
                              input bit pbit, input bit stop_ok, input bit rd);
    bit pe;
    pe = pen && ((($countones(d) + int'(pbit)) % 2) != int'(ptype));
    m_done++;
    if (!m_valid || rd) begin
      m_data = d; m_perr = pe; m_ferr = !stop_ok; m_valid = 1;
      if (rd) m_ovr = 0;
    end else begin
      m_ovr = 1;
    end
  endtask

  task automatic do_read();
    @(posedge clk); #1 read = 1'b1;
    @(posedge clk); #1 read = 1'b0;
    if (m_valid) begin m_valid = 0; m_ovr = 0; end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptype,
                            input bit pbit, input bit stop_ok);
    enable_parity = pen;
    parity_type   = ptype;
    @(posedge clk); #1 rx = 1'b0;
    start_cyc = cyc;
    repeat (CLKS) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 2) begin enable_parity = ~pen; parity_type = ~ptype; end
      repeat (CLKS) @(posedge clk);
      #1;
    end
    if (pen) begin
      rx = pbit;
      repeat (CLKS) @(posedge clk);
      #1;
    end
    rx = stop_ok;
    repeat (CLKS) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({rx_data, data_valid, done, busy, parity_error, frame_error, overrun} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {rx_data, data_valid, done, busy, parity_error, frame_error, overrun});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 0, 0, 0, 1);
    model_commit(8'hA5, 0, 0, 0, 1, 0);
    // rx low at start_cyc -> rx_s low 2 edges later -> t0 ends on 3rd edge; commit at t0+95.
    total++;
    if (done_cyc - start_cyc !== 98) begin
      bad++; $display("FAIL commit_latency: got %0d want 98", done_cyc - start_cyc);
    end
    total++;
    if ({rx_data, data_valid, parity_error, frame_error, overrun} !== {m_data, m_valid, m_perr, m_ferr, m_ovr}) begin
      bad++; $display("FAIL basic_frame: got %h want %h",
        {rx_data, data_valid, parity_error, frame_error, overrun}, {m_data, m_valid, m_perr, m_ferr, m_ovr});
    end
    total++;
    if (busy !== 1'b0 || done_count !== m_done) begin
      bad++; $display("FAIL basic_busy_done: busy=%b done_count=%0d want busy=0 done_count=%0d", busy, done_count, m_done);
    end
    @(posedge clk); #1 read = 1'b1;
    #1;
    total++;
    if (data_valid !== 1'b1) begin
      bad++; $display("FAIL read_registered: data_valid=%b want 1 before edge", data_valid);
    end
    @(posedge clk); #1 read = 1'b0;
    m_valid = 0; m_ovr = 0;
    total++;
    if (data_valid !== 1'b0) begin
      bad++; $display("FAIL read_clear: data_valid=%b want 0", data_valid);
    end
  endtask

  task automatic test_parity();
    send_frame(8'hA5, 1, 0, 0, 1);
    model_commit(8'hA5, 1, 0, 0, 1, 0);
    total++;
    if ({rx_data, data_valid, parity_error, frame_error} !== {m_data, m_valid, m_perr, m_ferr}) begin
      bad++; $display("FAIL parity_even: got %h want %h",
        {rx_data, data_valid, parity_error, frame_error}, {m_data, m_valid, m_perr, m_ferr});
    end
    do_read();
    send_frame(8'hA5, 1, 1, 0, 1);
    model_commit(8'hA5, 1, 1, 0, 1, 0);
    total++;
    if ({rx_data, data_valid, parity_error, frame_error} !== {m_data, m_valid, m_perr, m_ferr}) begin
      bad++; $display("FAIL parity_odd: got %h want %h",
        {rx_data, data_valid, parity_error, frame_error}, {m_data, m_valid, m_perr, m_ferr});
    end
    do_read();
  endtask

  task automatic test_glitch_framing();
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL glitch_busy: busy=%b want 1", busy);
    end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done_count !== m_done || data_valid !== 1'b0) begin
      bad++; $display("FAIL glitch_reject: busy=%b done_count=%0d dv=%b want 0 %0d 0", busy, done_count, data_valid, m_done);
    end
    send_frame(8'h3C, 0, 0, 0, 0);
    model_commit(8'h3C, 0, 0, 0, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    total++;
    if ({rx_data, data_valid, parity_error, frame_error, overrun} !== {m_data, m_valid, m_perr, m_ferr, m_ovr}
        || done_count !== m_done) begin
      bad++; $display("FAIL framing: got %h done=%0d want %h done=%0d",
        {rx_data, data_valid, parity_error, frame_error, overrun}, done_count, {m_data, m_valid, m_perr, m_ferr, m_ovr}, m_done);
    end
    do_read();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 0, 0, 0, 1);
    model_commit(8'h11, 0, 0, 0, 1, 0);
    send_frame(8'h22, 0, 0, 0, 1);
    model_commit(8'h22, 0, 0, 0, 1, 0);
    total++;
    if ({rx_data, data_valid, overrun} !== {m_data, m_valid, m_ovr} || done_count !== m_done) begin
      bad++; $display("FAIL overrun_set: got %h done=%0d want %h done=%0d",
        {rx_data, data_valid, overrun}, done_count, {m_data, m_valid, m_ovr}, m_done);
    end
    do_read();
    total++;
    if ({data_valid, overrun} !== {m_valid, m_ovr}) begin
      bad++; $display("FAIL overrun_clear: got %b want %b", {data_valid, overrun}, {m_valid, m_ovr});
    end
  endtask

  task automatic test_read_at_commit();
    send_frame(8'h11, 0, 0, 0, 1);
    model_commit(8'h11, 0, 0, 0, 1, 0);
    send_frame(8'h33, 0, 0, 0, 1);
    model_commit(8'h33, 0, 0, 0, 1, 0);
    fork
      send_frame(8'h22, 0, 0, 0, 1);
      begin
        @(posedge clk); #1;
        repeat (97) @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk); #1 read = 1'b0;
      end
    join
    model_commit(8'h22, 0, 0, 0, 1, 1);
    total++;
    if ({rx_data, data_valid, overrun} !== {m_data, m_valid, m_ovr}) begin
      bad++; $display("FAIL read_at_commit: got %h want %h", {rx_data, data_valid, overrun}, {m_data, m_valid, m_ovr});
    end
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1 rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midframe_busy: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    m_valid = 0; m_data = '0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    total++;
    if ({rx_data, data_valid, done, busy, parity_error, frame_error, overrun} !== 14'h0) begin
      bad++; $display("FAIL midframe_reset: got %h want 0",
        {rx_data, data_valid, done, busy, parity_error, frame_error, overrun});
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    total++;
    if (done_count !== m_done || data_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midframe_nocommit: done=%0d dv=%b busy=%b want done=%0d dv=0 busy=0", done_count, data_valid, busy, m_done);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 0, 0, 0, 1);
    model_commit(8'h01, 0, 0, 0, 1, 0);
    total++;
    if ({rx_data, data_valid} !== {m_data, m_valid}) begin
      bad++; $display("FAIL b2b_first: got %h want %h", {rx_data, data_valid}, {m_data, m_valid});
    end
    fork
      send_frame(8'hFE, 0, 0, 0, 1);
      begin
        repeat (20) @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk); #1 read = 1'b0;
        m_valid = 0; m_ovr = 0;
      end
    join
    model_commit(8'hFE, 0, 0, 0, 1, 0);
    total++;
    if ({rx_data, data_valid, overrun} !== {m_data, m_valid, m_ovr} || done_count !== m_done
        || done_cyc - start_cyc !== 98) begin
      bad++; $display("FAIL b2b_second: got %h done=%0d lat=%0d want %h done=%0d lat=98",
        {rx_data, data_valid, overrun}, done_count, done_cyc - start_cyc, {m_data, m_valid, m_ovr}, m_done);
    end
    do_read();
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit pen, ptype, pbit, stop_ok;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      pen = 1'($urandom);
      ptype = 1'($urandom);
      pbit = 1'($urandom);
      stop_ok = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 1) do_read();
      send_frame(d, pen, ptype, pbit, stop_ok);
      model_commit(d, pen, ptype, pbit, stop_ok, 0);
      repeat (30) @(posedge clk);
      #1;
      total++;
      if ({rx_data, data_valid, parity_error, frame_error, overrun} !== {m_data, m_valid, m_perr, m_ferr, m_ovr}
          || done_count !== m_done || busy !== 1'b0) begin
        bad++; $display("FAIL random_%0d: got %h done=%0d busy=%b want %h done=%0d busy=0", n,
          {rx_data, data_valid, parity_error, frame_error, overrun}, done_count, busy,
          {m_data, m_valid, m_perr, m_ferr, m_ovr}, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch_framing();
    test_overrun();
    test_read_at_commit();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
